// File: rtl/sd_decim_pkg.sv
// Shared types and helpers for the sigma-delta decimation scheduler.
// Holds the FSM states, default sizes, FIFO entry and round-robin pick.
package sd_decim_pkg;

  localparam int NCH_DEF = 4;
  localparam int CHW_DEF = 2;
  localparam int RW_DEF  = 10;
  localparam int DW_DEF  = 33;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ACCUM,
    DUMP,
    CAPTURE,
    STALL
  } state_e;

  typedef struct packed {
    logic [CHW_DEF-1:0] ch;
    logic [DW_DEF-1:0]  data;
  } fifo_entry_t;

  // First set mask bit strictly after ptr, wrapping modulo nch.
  function automatic logic [2:0] rr_pick(
    input logic [7:0] mask,
    input logic [2:0] ptr,
    input int         nch
  );
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i <= nch) begin
        idx = 3'((int'(ptr) + i) % nch);
        if (!found && mask[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sd_decim_out_fifo.sv
// Two-entry result FIFO with valid/ready output.
// Push into a full FIFO is accepted when a pop happens in the same cycle.
module sd_decim_out_fifo
  import sd_decim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  fifo_entry_t push_data_i,
  input  logic        pop_i,
  output fifo_entry_t out_o,
  output logic        valid_o,
  output logic        full_o,
  output logic        empty_o
);

  fifo_entry_t mem_q [2];
  logic        rd_q;
  logic [1:0]  cnt_q;
  logic        wr_idx;
  logic        do_pop;
  logic        do_push;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign valid_o = !empty_o;
  assign out_o   = mem_q[rd_q];
  assign wr_idx  = rd_q ^ cnt_q[0];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_idx] <= push_data_i;
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/sd_decim_sched.sv
// Round-robin scheduler sharing one decimation accumulator among channels.
// Runs clear/accumulate/dump per block and queues tagged results.
module sd_decim_sched
  import sd_decim_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CHW = CHW_DEF,
  parameter int RW  = RW_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_enable,
  input  logic [RW-1:0]  cfg_ratio,
  input  logic [NCH-1:0] cfg_ch_mask,
  input  logic [NCH-1:0] ch_valid,
  output logic [NCH-1:0] ch_ack,
  output logic [CHW-1:0] ch_sel,
  output logic           dec_acc_clr,
  output logic           dec_acc_en,
  output logic           dec_dump,
  input  logic [DW-1:0]  dec_result,
  output logic [DW-1:0]  out_data,
  output logic [CHW-1:0] out_ch,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic           ovf_sticky,
  input  logic           ovf_clr
);

  state_e         state_q;
  logic [CHW-1:0] ch_sel_q;
  logic [CHW-1:0] rr_q;
  logic [RW-1:0]  ratio_q;
  logic [RW-1:0]  cnt_q;
  logic [DW-1:0]  hold_q;
  logic           ovf_q;

  logic [CHW-1:0] next_ch;
  logic [RW-1:0]  ratio_eff;
  logic [RW-1:0]  cnt_inc;
  logic           mask_any;
  logic           accept;
  logic           room;
  logic           push;
  logic           pop;
  logic           fifo_full;
  logic           fifo_empty;
  fifo_entry_t    push_ent;
  fifo_entry_t    out_ent;

  assign next_ch   = CHW'(rr_pick(8'(cfg_ch_mask), 3'(rr_q), NCH));
  assign ratio_eff = (cfg_ratio == '0) ? RW'(1) : cfg_ratio;
  assign cnt_inc   = cnt_q + RW'(1);
  assign mask_any  = |cfg_ch_mask;
  assign accept    = (state_q == ACCUM) && ch_valid[ch_sel_q];

  assign pop  = out_valid && out_ready;
  assign room = !fifo_full || pop;
  assign push = ((state_q == CAPTURE) || (state_q == STALL)) && room;

  assign push_ent.ch   = ch_sel_q;
  assign push_ent.data = (state_q == CAPTURE) ? dec_result : hold_q;

  assign ch_ack      = accept ? (NCH'(1) << ch_sel_q) : '0;
  assign dec_acc_en  = accept;
  assign dec_acc_clr = (state_q == SELECT);
  assign dec_dump    = (state_q == DUMP);
  assign busy        = (state_q != IDLE);
  assign ch_sel      = ch_sel_q;
  assign ovf_sticky  = ovf_q;
  assign out_data    = out_ent.data;
  assign out_ch      = out_ent.ch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ch_sel_q <= '0;
      rr_q     <= CHW'(NCH - 1);
      ratio_q  <= RW'(1);
      cnt_q    <= '0;
      hold_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_enable && mask_any) state_q <= SELECT;
        end
        SELECT: begin
          ratio_q <= ratio_eff;
          cnt_q   <= '0;
          if (mask_any) begin
            ch_sel_q <= next_ch;
            rr_q     <= next_ch;
            state_q  <= ACCUM;
          end else begin
            state_q  <= IDLE;
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == ratio_q) state_q <= DUMP;
          end
        end
        DUMP: state_q <= CAPTURE;
        CAPTURE: begin
          hold_q <= dec_result;
          if (room) state_q <= cfg_enable ? SELECT : IDLE;
          else      state_q <= STALL;
        end
        STALL: begin
          if (room) state_q <= cfg_enable ? SELECT : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Set wins over clear so a refusal in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if ((state_q == STALL) && |(ch_valid & cfg_ch_mask)) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  sd_decim_out_fifo u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .push_i     (push),
    .push_data_i(push_ent),
    .pop_i      (pop),
    .out_o      (out_ent),
    .valid_o    (out_valid),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: tb/tb_sd_decim_sched.sv
// Directed bench for sd_decim_sched with a behavioural accumulator model.
// Table-driven cycle vectors plus hand-written multi-cycle sequences.
module tb_sd_decim_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_enable;
  logic [9:0]  cfg_ratio;
  logic [3:0]  cfg_ch_mask;
  logic [3:0]  ch_valid;
  logic [3:0]  ch_ack;
  logic [1:0]  ch_sel;
  logic        dec_acc_clr;
  logic        dec_acc_en;
  logic        dec_dump;
  logic [32:0] dec_result;
  logic [32:0] out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        ovf_sticky;
  logic        ovf_clr;

  logic [32:0] acc;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_decim_sched dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_enable (cfg_enable),
    .cfg_ratio  (cfg_ratio),
    .cfg_ch_mask(cfg_ch_mask),
    .ch_valid   (ch_valid),
    .ch_ack     (ch_ack),
    .ch_sel     (ch_sel),
    .dec_acc_clr(dec_acc_clr),
    .dec_acc_en (dec_acc_en),
    .dec_dump   (dec_dump),
    .dec_result (dec_result),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr)
  );

  // Datapath model: each sample of channel c contributes c+1.
  always @(posedge clk) begin
    if (dec_acc_clr) acc <= '0;
    else if (dec_acc_en) acc <= acc + 33'(ch_sel) + 33'd1;
    if (dec_dump) dec_result <= acc;
  end

  typedef struct {
    logic        en;
    logic [9:0]  ratio;
    logic [3:0]  mask;
    logic [3:0]  vld;
    logic        rdy;
    logic        busy;
    logic        clr;
    logic [3:0]  ack;
    logic        dump;
    logic        ov;
    logic [1:0]  och;
    logic [32:0] od;
  } vec_t;

  vec_t tv [10];

  function automatic vec_t mk(
    logic en, logic [9:0] r, logic [3:0] m, logic [3:0] v, logic rd,
    logic b, logic c, logic [3:0] a, logic d, logic o,
    logic [1:0] oc, logic [32:0] odat
  );
    vec_t x;
    x.en = en; x.ratio = r; x.mask = m; x.vld = v; x.rdy = rd;
    x.busy = b; x.clr = c; x.ack = a; x.dump = d; x.ov = o;
    x.och = oc; x.od = odat;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cfg_enable = 1'b0; cfg_ratio = '0; cfg_ch_mask = '0;
    ch_valid = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_clr(input string nm);
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!dec_acc_clr && n < 20);
    chk(nm, dec_acc_clr, 1);
  endtask

  initial begin
    int got, acks, pops, bad;
    logic [1:0]  e_ch [3];
    logic [32:0] e_dt [3];
    logic        pat [7];
    logic        dropped;

    // ---- reset state ----
    do_reset();
    reset = 1'b0; #1;
    chk("rst_busy", busy, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_sel", ch_sel, 0);
    chk("rst_od", out_data, 0);
    @(posedge clk); #1 reset = 1'b1;

    // ---- table: ratio 0 on ch0, 4-cycle block ----
    tv[0] = mk(1, 0, 4'b0001, 4'hf, 1, 0, 0, 4'b0000, 0, 0, 0, 0);
    tv[1] = mk(1, 0, 4'b0001, 4'hf, 1, 1, 1, 4'b0000, 0, 0, 0, 0);
    tv[2] = mk(1, 0, 4'b0001, 4'hf, 1, 1, 0, 4'b0001, 0, 0, 0, 0);
    tv[3] = mk(1, 0, 4'b0001, 4'hf, 1, 1, 0, 4'b0000, 1, 0, 0, 0);
    tv[4] = mk(1, 0, 4'b0001, 4'hf, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    tv[5] = mk(1, 0, 4'b0001, 4'hf, 1, 1, 1, 4'b0000, 0, 1, 0, 1);
    tv[6] = mk(1, 0, 4'b0001, 4'hf, 1, 1, 0, 4'b0001, 0, 0, 0, 0);
    tv[7] = mk(1, 0, 4'b0001, 4'hf, 1, 1, 0, 4'b0000, 1, 0, 0, 0);
    tv[8] = mk(1, 0, 4'b0001, 4'hf, 1, 1, 0, 4'b0000, 0, 0, 0, 0);
    tv[9] = mk(1, 0, 4'b0001, 4'hf, 1, 1, 1, 4'b0000, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cfg_enable = tv[i].en; cfg_ratio = tv[i].ratio;
      cfg_ch_mask = tv[i].mask; ch_valid = tv[i].vld;
      out_ready = tv[i].rdy;
      #1;
      chk($sformatf("t%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("t%0d_clr", i), dec_acc_clr, tv[i].clr);
      chk($sformatf("t%0d_ack", i), ch_ack, tv[i].ack);
      chk($sformatf("t%0d_en", i), dec_acc_en, |tv[i].ack);
      chk($sformatf("t%0d_dump", i), dec_dump, tv[i].dump);
      chk($sformatf("t%0d_ov", i), out_valid, tv[i].ov);
      if (tv[i].ov) begin
        chk($sformatf("t%0d_och", i), out_ch, tv[i].och);
        chk($sformatf("t%0d_od", i), out_data, tv[i].od);
      end
    end

    // ---- mask 0101, ratio 4: ch0, ch2, ch0 ----
    do_reset();
    cfg_ch_mask = 4'b0101; cfg_ratio = 10'd4; ch_valid = 4'hf;
    out_ready = 1'b1; cfg_enable = 1'b1;
    e_ch = '{2'd0, 2'd2, 2'd0};
    e_dt = '{33'd4, 33'd12, 33'd4};
    got = 0; acks = 0; bad = 0;
    for (int c = 0; c < 80 && got < 3; c++) begin
      @(posedge clk); #2;
      if ($countones(ch_ack) > 1 || dec_acc_en != |ch_ack) bad++;
      if (dec_acc_en) acks++;
      if (dec_dump) begin
        chk("rr_blk_acks", acks, 4);
        acks = 0;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("rr_och%0d", got), out_ch, e_ch[got]);
        chk($sformatf("rr_od%0d", got), out_data, e_dt[got]);
        got++;
      end
    end
    chk("rr_got", got, 3);
    chk("rr_onehot", bad, 0);

    // ---- gapped ch_valid on ch1 ----
    do_reset();
    cfg_ch_mask = 4'b0010; cfg_ratio = 10'd4; out_ready = 1'b1;
    cfg_enable = 1'b1;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    wait_clr("gap_sel");
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      ch_valid = pat[k] ? 4'b0010 : 4'b0000;
      #1;
      chk($sformatf("gap_ack%0d", k), ch_ack, pat[k] ? 4'b0010 : 4'b0000);
      chk($sformatf("gap_nodump%0d", k), dec_dump, 0);
    end
    @(posedge clk); #1 ch_valid = '0; #1;
    chk("gap_dump", dec_dump, 1);
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("gap_ov", out_valid, 1);
    chk("gap_och", out_ch, 1);
    chk("gap_od", out_data, 8);

    // ---- backpressure: fill, stall, drain ----
    do_reset();
    cfg_ch_mask = 4'b0011; cfg_ratio = 10'd2; ch_valid = 4'hf;
    out_ready = 1'b0; cfg_enable = 1'b1;
    repeat (25) @(posedge clk);
    #2;
    chk("st_busy", busy, 1);
    chk("st_ack", ch_ack, 0);
    chk("st_ovf", ovf_sticky, 1);
    chk("st_ov", out_valid, 1);
    e_ch = '{2'd0, 2'd1, 2'd0};
    e_dt = '{33'd2, 33'd4, 33'd2};
    cfg_enable = 1'b0; out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (out_valid) begin
        chk($sformatf("st_och%0d", got), out_ch, e_ch[got]);
        chk($sformatf("st_od%0d", got), out_data, e_dt[got]);
        got++;
      end
      @(posedge clk); #2;
    end
    chk("st_got", got, 3);
    chk("st_empty", out_valid, 0);
    chk("st_idle", busy, 0);
    chk("st_ovf_hold", ovf_sticky, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #2;
    ovf_clr = 1'b0;
    chk("st_ovf_clr", ovf_sticky, 0);

    // ---- enable dropped mid-block, ratio 8 ----
    do_reset();
    cfg_ch_mask = 4'b0001; cfg_ratio = 10'd8; ch_valid = 4'hf;
    out_ready = 1'b1; cfg_enable = 1'b1;
    wait_clr("dis_sel");
    acks = 0; pops = 0; dropped = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (dec_acc_en) acks++;
      if (acks == 2 && !dropped) begin
        cfg_enable = 1'b0;
        dropped = 1'b1;
      end
      if (out_valid) begin
        pops++;
        chk("dis_od", out_data, 8);
        chk("dis_och", out_ch, 0);
      end
      if (!busy) break;
    end
    repeat (5) begin
      @(posedge clk); #2;
      if (dec_acc_en) acks++;
    end
    chk("dis_acks", acks, 8);
    chk("dis_pops", pops, 1);
    chk("dis_busy", busy, 0);

    // ---- async reset mid-block with queued result ----
    do_reset();
    cfg_ch_mask = 4'b0101; cfg_ratio = 10'd4; ch_valid = 4'hf;
    out_ready = 1'b0; cfg_enable = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (out_valid && ch_ack != 0) begin
        got = 1;
        break;
      end
    end
    chk("ar_reach", got, 1);
    #1 reset = 1'b0;
    #1;
    chk("ar_ack", ch_ack, 0);
    chk("ar_sel", ch_sel, 0);
    chk("ar_clr", dec_acc_clr, 0);
    chk("ar_en", dec_acc_en, 0);
    chk("ar_dump", dec_dump, 0);
    chk("ar_od", out_data, 0);
    chk("ar_och", out_ch, 0);
    chk("ar_ov", out_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ovf", ovf_sticky, 0);
    @(posedge clk); #1 reset = 1'b1; out_ready = 1'b1;
    wait_clr("ar_sel2");
    @(posedge clk); #2;
    chk("ar_ack0", ch_ack, 4'b0001);
    chk("ar_ch0", ch_sel, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_decim_sched.md
Name: sd_decim_sched

Overview:
- Time-multiplexes one shared sigma-delta decimation accumulator among NCH modulator channels.
- Picks the next channel round-robin and runs exactly one decimation block on it: clear, accumulate cfg_ratio samples, dump.
- Captures the decimator result and queues it, tagged with its channel, in a 2-entry output FIFO with a valid/ready handshake.
- Sits between the per-channel sinc filter outputs and the sd_decimation-style accumulator datapath.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- CHW, 2, channel index width, equal to clog2(NCH).
- RW, 10, width of the ratio and sample counter.
- DW, 33, decimated result width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_enable  in  1  run enable.
- cfg_ratio  in  RW  samples per block; 0 is treated as 1.
- cfg_ch_mask  in  NCH  enabled channels.
- ch_valid  in  NCH  channel has a filtered sample this cycle.
- ch_ack  out  NCH  one-hot; sample of the selected channel consumed.
- ch_sel  out  CHW  datapath input mux select.
- dec_acc_clr  out  1  clear the shared accumulator.
- dec_acc_en  out  1  add the selected sample to the accumulator.
- dec_dump  out  1  request the result.
- dec_result  in  DW  result, valid the cycle after dec_dump.
- out_data  out  DW  queued result.
- out_ch  out  CHW  channel tag of out_data.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accepts.
- busy  out  1  FSM not in IDLE.
- ovf_sticky  out  1  samples were refused during a stall.
- ovf_clr  in  1  clears ovf_sticky.

Behaviour:
- Reset (reset=0, async): FSM=IDLE, rr_ptr=NCH-1, FIFO empty. All outputs 0.
- States:
  - IDLE: when cfg_enable=1 and cfg_ch_mask!=0, go to SELECT; otherwise stay.
  - SELECT (1 cycle):
    - Pick the first masked channel after rr_ptr, cyclic; update ch_sel and rr_ptr.
    - Latch ratio_q = max(cfg_ratio,1) and cnt=0; assert dec_acc_clr.
    - If the mask is now 0, go to IDLE; otherwise go to ACCUM.
  - ACCUM:
    - Each cycle with ch_valid[ch_sel]=1: dec_acc_en=1, ch_ack[ch_sel]=1, cnt++.
    - When the sample accepted makes cnt==ratio_q, go to DUMP.
    - Cycles with no valid sample do not count.
  - DUMP (1 cycle): dec_dump=1, then CAPTURE.
  - CAPTURE:
    - Latch dec_result into the hold register.
    - If the FIFO has room (not full, or a pop this cycle), push {ch_sel, result}; otherwise go to STALL.
    - After a push: go to SELECT if cfg_enable=1, else IDLE.
  - STALL:
    - Push the hold register as soon as there is room, then take the same next-state choice as CAPTURE.
    - ch_ack stays 0.
- Latency: last accepted sample at cycle c, DUMP at c+1, CAPTURE/push at c+2, out_valid=1 at c+3 when the FIFO was empty.
- FIFO:
  - Push and pop in the same cycle are legal, including when full.
  - out_data/out_ch hold steady while out_valid=1 and out_ready=0.
  - Ordering is strict FIFO.
- Configuration timing:
  - cfg_ratio and cfg_ch_mask are sampled only in SELECT.
  - Mid-block changes affect the next block only.
  - The current channel completes its block even if it is masked off.
- cfg_enable deasserted mid-block: the block completes through capture and push, then the FSM goes to IDLE. Results are never partial.
- ovf_sticky:
  - Set in any STALL cycle where ch_valid & cfg_ch_mask != 0.
  - Cleared by ovf_clr; set has priority when both occur in the same cycle.
- Single-channel mask: that channel is reselected every block.
- Reset mid-block: immediate return to IDLE and the FIFO contents are discarded; no dump is issued.
- At most one ch_ack bit is high per cycle; dec_acc_en equals |ch_ack.

Decomposition:
- Package sd_decim_pkg holds:
  - the state enum {IDLE, SELECT, ACCUM, DUMP, CAPTURE, STALL};
  - the default parameter values;
  - the FIFO entry struct {ch, data}.
- Sub-module sd_decim_out_fifo: 2-entry FIFO with valid/ready, push/pop, full and empty.
- Round-robin pick is a combinational function in the package.

Test Plan:
- Mask=4'b0101, ratio=4, all ch_valid=1, out_ready=1:
  - blocks alternate ch0, ch2, ch0, …;
  - each block has 4 ack cycles;
  - out_ch sequence 0, 2, 0.
- Ratio=0, mask=4'b0001: treated as 1; exactly 1 ack per block; one dec_dump every 4 cycles (SELECT, ACCUM, DUMP, CAPTURE).
- Gapped ch_valid on ch1 (pattern 1,0,0,1,1,0,1), ratio=4: DUMP follows the 4th valid cycle; the count skips idle cycles.
- out_ready=0 over 3 blocks with ch_valid held high:
  - FIFO fills to 2, then STALL with ch_ack=0 and ovf_sticky=1;
  - out_ready=1 then drains results in order and the third result is pushed;
  - ovf_clr=1 drops ovf_sticky.
- cfg_enable dropped at the 2nd sample of a ratio=8 block: all 8 samples are accepted, one result is pushed, FSM returns to IDLE, busy=0.
- Assert reset during ACCUM with a non-empty FIFO: all outputs 0 immediately (async), out_valid=0, the next run starts at ch0.
